spu_sm_expu_pwl_array: RTL and testbench
========================================

SPU_SM_EXPU_PWL_ARRAY -- requirements
Module: spu_sm_expu_pwl_array

Interface
REQ-001 SHALL have parameter LANES, default 4, parallel exp lanes.
REQ-002 SHALL have parameter NSEG, default 8, PWL segments (NSEG-1 breakpoints), power of two, 2..16.
REQ-003 SHALL have parameter DIN_W, default 9, signed input width; DOUT_W, default 8, unsigned output width.
REQ-004 SHALL have ports: core_clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: cfg_we in 1 table write; cfg_sel in 2 table select (0 breakpoint Q3.4, 1 coeff Q1.6, 2 bias Q1.6); cfg_addr in $clog2(NSEG) entry; cfg_wdata in 8 signed entry value.
REQ-006 SHALL have ports: input_scale_shift in 4 (iss); output_scale_shift in 4 (oss); prep in 1 start pulse; stop in 1 drain request; busy out 1 state!=IDLE.
REQ-007 SHALL have ports: in_valid in 1; in_ready out 1; in_data in LANES*DIN_W (lane k at bits [k*DIN_W +: DIN_W]); out_valid out 1; out_ready in 1; out_data out LANES*DOUT_W.

Function
REQ-008 SHALL implement FSM IDLE -> PREP (prep=1) -> RUN (after NSEG-1 PREP cycles) -> DRAIN (stop=1) -> IDLE (pipeline empty); prep outside IDLE and stop outside RUN ignored.
REQ-009 SHALL sample iss/oss into registers on the prep cycle; later port changes have no effect until next prep.
REQ-010 SHALL in PREP compute one breakpoint per cycle (index counter 0..NSEG-2): bp_q[i] = sign-extended bp_f[i] << iss, arithmetic >>4, saturated to [-256,255].
REQ-011 SHALL accept cfg_we only in IDLE; writes in other states ignored; cfg_sel=3 ignored; addr NSEG-1 ignored for breakpoints.
REQ-012 SHALL select per lane seg = count of i with x >= bp_q[i] (breakpoints ascending; equality goes to upper segment).
REQ-013 SHALL compute acc (24-bit signed) = coeff[seg]*x + (bias[seg] << iss).
REQ-014 SHALL output clamp(acc >>> oss, 0, 2^DOUT_W-1), truncating unless REQ-022 applies.
REQ-015 SHALL be a 2-stage pipeline (S1 segment select, S2 MAC/shift/clamp); transfer on valid&ready; latency 2 cycles with out_ready=1; one vector/cycle throughput.
REQ-016 SHALL drive in_ready = (state==RUN) & (!S1_valid | S1 advancing); S2 holds while out_valid & !out_ready; out_data stable while stalled.
REQ-017 SHALL in DRAIN deassert in_ready and return to IDLE the cycle after S1 and S2 are both empty and no output is pending.
REQ-018 SHALL preserve vector order; no loss or duplication under any backpressure pattern.

Reset
REQ-019 SHALL on rst_n low: state IDLE, out_valid 0, in_ready 0, busy 0, out_data 0, pipeline valids 0, iss/oss 0, bp_q 0.
REQ-020 SHALL reset tables to defaults: bp_f {-88,-53,-38,-25,-22,-12,-5}, coeff {0,1,4,9,15,23,38,55}, bias {0,5,15,27,37,47,58,64} (NSEG=8; other NSEG zero-filled).
REQ-021 SHALL, when reset asserts mid-PREP/RUN, abort immediately; prep required again after release.

Configuration
REQ-022 SHALL with SPU_SM_EXPU_ROUND_EN defined add 1<<(oss-1) to acc before the shift when oss>0 (round-half-up); without it, truncate.

Structure
REQ-023 SHALL place in shared package spu_sm_pkg: FSM state enum, cfg_sel encodings, default table constants, ACC_W=24.
REQ-024 SHALL implement per-lane datapath (S1/S2) as sub-module spu_sm_expu_pwl_lane, instantiated LANES times by generate; FSM/tables/PREP in top.

Verification
REQ-025 Defaults, prep iss=4 oss=3, x=0 -> seg 7, acc 1024, out 128; oss=2 -> out 255 (saturate).
REQ-026 iss=4 oss=3, x=-20 -> seg 5, acc 292, out 36 (37 with SPU_SM_EXPU_ROUND_EN); x=-256 -> seg 0, out 0.
REQ-027 iss=15 prep -> all bp_q=-256; any x -> seg 7.
REQ-028 RUN, out_ready low 3 cycles while 4 vectors offered -> 2 accepted then in_ready 0; after release all 4 emerge in order, none duplicated.
REQ-029 cfg_we in RUN writing coeff[7]=0 -> ignored, x=0 still 128; stop with 2 in flight -> both delivered, then busy 0.
REQ-030 rst_n low during PREP -> next cycle busy 0, out_valid 0, tables at defaults.

Source files
------------

// File: rtl/spu_sm_pkg.sv
// Shared types, table defaults and helpers for the softmax exp unit.
package spu_sm_pkg;

  localparam int ACC_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    SEL_BP    = 2'd0,
    SEL_COEFF = 2'd1,
    SEL_BIAS  = 2'd2,
    SEL_NONE  = 2'd3
  } cfg_sel_e;

  localparam logic signed [7:0] DEF_BP [0:6] = '{
    -8'sd88, -8'sd53, -8'sd38, -8'sd25,
    -8'sd22, -8'sd12, -8'sd5
  };

  localparam logic signed [7:0] DEF_COEFF [0:7] = '{
    8'sd0, 8'sd1, 8'sd4, 8'sd9,
    8'sd15, 8'sd23, 8'sd38, 8'sd55
  };

  localparam logic signed [7:0] DEF_BIAS [0:7] = '{
    8'sd0, 8'sd5, 8'sd15, 8'sd27,
    8'sd37, 8'sd47, 8'sd58, 8'sd64
  };

  function automatic logic signed [7:0] def_bp(
    input int nseg,
    input int i
  );
    if (nseg == 8 && i >= 0 && i < 7) return DEF_BP[i];
    return '0;
  endfunction

  function automatic logic signed [7:0] def_coeff(
    input int nseg,
    input int i
  );
    if (nseg == 8 && i >= 0 && i < 8) return DEF_COEFF[i];
    return '0;
  endfunction

  function automatic logic signed [7:0] def_bias(
    input int nseg,
    input int i
  );
    if (nseg == 8 && i >= 0 && i < 8) return DEF_BIAS[i];
    return '0;
  endfunction

  // Q3.4 breakpoint scaled into the input domain, saturated to 9 bits.
  function automatic logic signed [8:0] bp_scale(
    input logic signed [7:0] f,
    input logic [3:0]        s
  );
    logic signed [ACC_W-1:0] t;
    t = {{(ACC_W-8){f[7]}}, f};
    t = (t <<< s) >>> 4;
    if (t > 24'sd255) return 9'sd255;
    if (t < -24'sd256) return -9'sd256;
    return t[8:0];
  endfunction

endpackage

// File: rtl/spu_sm_expu_pwl_lane.sv
// One exp lane: S1 segment select, S2 MAC/shift/clamp.
// SPU_SM_EXPU_ROUND_EN enables round-half-up before the output shift.
module spu_sm_expu_pwl_lane
  import spu_sm_pkg::*;
#(
  parameter int NSEG   = 8,
  parameter int DIN_W  = 9,
  parameter int DOUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s1_en,
  input  logic                   s2_en,
  input  logic [3:0]             iss,
  input  logic [3:0]             oss,
  input  logic [DIN_W-1:0]       x,
  input  logic [(NSEG-1)*9-1:0]  bp,
  input  logic [NSEG*8-1:0]      coeff,
  input  logic [NSEG*8-1:0]      bias,
  output logic [DOUT_W-1:0]      dout
);

  localparam int AW = $clog2(NSEG);
  localparam logic signed [ACC_W-1:0] OMAX =
    ACC_W'((1 << DOUT_W) - 1);
`ifdef SPU_SM_EXPU_ROUND_EN
  localparam logic signed [ACC_W-1:0] ONE = 1;
`endif

  logic signed [DIN_W-1:0] x_q, x_d;
  logic [AW-1:0]           seg_q, seg_d;
  logic [DOUT_W-1:0]       dout_q, dout_d;

  logic signed [7:0]       cf, bs;
  logic signed [ACC_W-1:0] cf_e, bs_e, x_e;
  logic signed [ACC_W-1:0] acc, sh;

  always_comb begin
    x_d   = x_q;
    seg_d = seg_q;
    if (s1_en) begin
      x_d   = x;
      seg_d = '0;
      for (int i = 0; i < NSEG-1; i++) begin
        if ($signed(x) >= $signed(bp[i*9 +: 9]))
          seg_d = seg_d + AW'(1);
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    cf   = coeff[int'(seg_q)*8 +: 8];
    bs   = bias[int'(seg_q)*8 +: 8];
    cf_e = {{(ACC_W-8){cf[7]}}, cf};
    bs_e = {{(ACC_W-8){bs[7]}}, bs};
    x_e  = {{(ACC_W-DIN_W){x_q[DIN_W-1]}}, x_q};
    acc  = cf_e * x_e + (bs_e <<< iss);
`ifdef SPU_SM_EXPU_ROUND_EN
    if (oss != 4'd0)
      acc = acc + (ONE <<< (oss - 4'd1));
`endif
    sh = acc >>> oss;
    if (s2_en) begin
      if (sh < 0)
        dout_d = '0;
      else if (sh > OMAX)
        dout_d = OMAX[DOUT_W-1:0];
      else
        dout_d = sh[DOUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      seg_q  <= '0;
      dout_q <= '0;
    end else begin
      x_q    <= x_d;
      seg_q  <= seg_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/spu_sm_expu_pwl_array.sv
// PWL exp array: FSM, config tables, breakpoint prep, lane array.
// SPU_SM_EXPU_ROUND_EN selects rounding in the lanes.
module spu_sm_expu_pwl_array
  import spu_sm_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NSEG   = 8,
  parameter int DIN_W  = 9,
  parameter int DOUT_W = 8
) (
  input  logic                      core_clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic [$clog2(NSEG)-1:0]   cfg_addr,
  input  logic [7:0]                cfg_wdata,
  input  logic [3:0]                input_scale_shift,
  input  logic [3:0]                output_scale_shift,
  input  logic                      prep,
  input  logic                      stop,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DIN_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DOUT_W-1:0]   out_data
);

  localparam int AW  = $clog2(NSEG);
  localparam int NBP = NSEG - 1;

  state_e            state_q, state_d;
  logic [3:0]        iss_q, iss_d, oss_q, oss_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic signed [7:0] bp_f_q  [NBP];
  logic signed [7:0] bp_f_d  [NBP];
  logic signed [7:0] coeff_q [NSEG];
  logic signed [7:0] coeff_d [NSEG];
  logic signed [7:0] bias_q  [NSEG];
  logic signed [7:0] bias_d  [NSEG];
  logic signed [8:0] bp_q    [NBP];
  logic signed [8:0] bp_d    [NBP];
  logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic              s1_en, s2_en;

  logic [NBP*9-1:0]  bp_flat;
  logic [NSEG*8-1:0] coeff_flat, bias_flat;

  // S1 advances whenever S2 is free or draining this cycle.
  always_comb begin
    s2_en    = s1_v_q & (~s2_v_q | out_ready);
    in_ready = (state_q == ST_RUN) & (~s1_v_q | s2_en);
    s1_en    = in_valid & in_ready;
    s1_v_d   = s1_en | (s1_v_q & ~s2_en);
    s2_v_d   = s2_en | (s2_v_q & ~out_ready);
  end

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    oss_d   = oss_q;
    idx_d   = idx_q;
    bp_d    = bp_q;
    bp_f_d  = bp_f_q;
    coeff_d = coeff_q;
    bias_d  = bias_q;
    unique case (state_q)
      ST_IDLE: begin
        if (prep) begin
          state_d = ST_PREP;
          iss_d   = input_scale_shift;
          oss_d   = output_scale_shift;
          idx_d   = '0;
        end
        if (cfg_we) begin
          unique case (cfg_sel_e'(cfg_sel))
            SEL_BP: begin
              if (int'(cfg_addr) < NBP)
                bp_f_d[cfg_addr] = cfg_wdata;
            end
            SEL_COEFF: coeff_d[cfg_addr] = cfg_wdata;
            SEL_BIAS:  bias_d[cfg_addr]  = cfg_wdata;
            SEL_NONE:  ;
          endcase
        end
      end
      ST_PREP: begin
        bp_d[idx_q] = bp_scale(bp_f_q[idx_q], iss_q);
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NSEG-2))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_v_q && !s2_v_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iss_q   <= '0;
      oss_q   <= '0;
      idx_q   <= '0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      for (int i = 0; i < NBP; i++) begin
        bp_f_q[i] <= def_bp(NSEG, i);
        bp_q[i]   <= '0;
      end
      for (int i = 0; i < NSEG; i++) begin
        coeff_q[i] <= def_coeff(NSEG, i);
        bias_q[i]  <= def_bias(NSEG, i);
      end
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      oss_q   <= oss_d;
      idx_q   <= idx_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      bp_f_q  <= bp_f_d;
      bp_q    <= bp_d;
      coeff_q <= coeff_d;
      bias_q  <= bias_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NBP; i++)
      bp_flat[i*9 +: 9] = bp_q[i];
    for (int i = 0; i < NSEG; i++) begin
      coeff_flat[i*8 +: 8] = coeff_q[i];
      bias_flat[i*8 +: 8]  = bias_q[i];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    spu_sm_expu_pwl_lane #(
      .NSEG   (NSEG),
      .DIN_W  (DIN_W),
      .DOUT_W (DOUT_W)
    ) u_lane (
      .clk   (core_clk),
      .rst_n (rst_n),
      .s1_en (s1_en),
      .s2_en (s2_en),
      .iss   (iss_q),
      .oss   (oss_q),
      .x     (in_data[k*DIN_W +: DIN_W]),
      .bp    (bp_flat),
      .coeff (coeff_flat),
      .bias  (bias_flat),
      .dout  (out_data[k*DOUT_W +: DOUT_W])
    );
  end

  assign out_valid = s2_v_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spu_sm_expu_pwl_array.sv
// Bench for spu_sm_expu_pwl_array: vector table, corner sequences,
// randomized traffic against an arithmetic reference model.
module tb_spu_sm_expu_pwl_array;

  localparam int LANES  = 4;
  localparam int NSEG   = 8;
  localparam int DIN_W  = 9;
  localparam int DOUT_W = 8;
  localparam int DW = LANES*DIN_W;
  localparam int OW = LANES*DOUT_W;
`ifdef SPU_SM_EXPU_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  localparam int DBP [7] = '{-88, -53, -38, -25, -22, -12, -5};
  localparam int DCF [8] = '{0, 1, 4, 9, 15, 23, 38, 55};
  localparam int DBS [8] = '{0, 5, 15, 27, 37, 47, 58, 64};

  logic          core_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [2:0]    cfg_addr = '0;
  logic [7:0]    cfg_wdata = '0;
  logic [3:0]    input_scale_shift = '0;
  logic [3:0]    output_scale_shift = '0;
  logic          prep = 1'b0;
  logic          stop = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;

  always #5 core_clk = ~core_clk;

  spu_sm_expu_pwl_array #(
    .LANES(LANES), .NSEG(NSEG), .DIN_W(DIN_W), .DOUT_W(DOUT_W)
  ) dut (
    .core_clk(core_clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .input_scale_shift(input_scale_shift),
    .output_scale_shift(output_scale_shift),
    .prep(prep), .stop(stop), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int checks = 0;
  int errors = 0;
  int bp_m [NSEG-1];
  int cf_m [NSEG];
  int bs_m [NSEG];
  int cur_iss = 0;
  int cur_oss = 0;
  logic [OW-1:0] exp_q [$];
  bit acc_f, out_f, rdy_s, busy_s, ov_s;
  logic [OW-1:0] od_s, last_out;
  int out_cnt = 0;
  int acc_cnt = 0;

  typedef struct {
    int iss;
    int oss;
    int x;
    int exp;
  } vec_t;
  vec_t tv [8];

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_defaults();
    for (int i = 0; i < NSEG-1; i++) bp_m[i] = DBP[i];
    for (int i = 0; i < NSEG; i++) begin
      cf_m[i] = DCF[i];
      bs_m[i] = DBS[i];
    end
  endfunction

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int model_lane(input int x);
    int seg, bp, acc, v;
    seg = 0;
    for (int i = 0; i < NSEG-1; i++) begin
      bp = floor_div(bp_m[i] * (1 << cur_iss), 16);
      if (bp > 255) bp = 255;
      if (bp < -256) bp = -256;
      if (x >= bp) seg++;
    end
    acc = cf_m[seg] * x + bs_m[seg] * (1 << cur_iss);
    v = acc;
    if (RND != 0 && cur_oss > 0) v = v + (1 << (cur_oss - 1));
    v = floor_div(v, 1 << cur_oss);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [OW-1:0] model_vec(input logic [DW-1:0] d);
    logic [OW-1:0] r;
    logic signed [DIN_W-1:0] xs;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      xs = d[k*DIN_W +: DIN_W];
      r[k*DOUT_W +: DOUT_W] = 8'(model_lane(int'(xs)));
    end
    return r;
  endfunction

  task automatic cyc();
    logic [OW-1:0] e;
    @(negedge core_clk);
    acc_f  = in_valid && in_ready;
    out_f  = out_valid && out_ready;
    rdy_s  = in_ready;
    busy_s = busy;
    ov_s   = out_valid;
    od_s   = out_data;
    if (acc_f) begin
      exp_q.push_back(model_vec(in_data));
      acc_cnt++;
    end
    if (out_f) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_out", longint'(out_data), longint'(e));
      end
      out_cnt++;
      last_out = out_data;
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic cfg_w(input int sel, input int addr, input int data,
                       input bit idle);
    cfg_we = 1'b1;
    cfg_sel = 2'(sel);
    cfg_addr = 3'(addr);
    cfg_wdata = 8'(data);
    cyc();
    cfg_we = 1'b0;
    if (idle) begin
      if (sel == 0 && addr < NSEG-1) bp_m[addr] = data;
      if (sel == 1) cf_m[addr] = data;
      if (sel == 2) bs_m[addr] = data;
    end
  endtask

  task automatic prep_run(input int iss, input int oss);
    int n;
    input_scale_shift = 4'(iss);
    output_scale_shift = 4'(oss);
    prep = 1'b1;
    cyc();
    prep = 1'b0;
    input_scale_shift = ~4'(iss);
    output_scale_shift = ~4'(oss);
    cur_iss = iss;
    cur_oss = oss;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (rdy_s) break;
      n++;
    end
    check("prep_cycles", n, NSEG-1);
  endtask

  task automatic stop_drain();
    bit got;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!busy_s) begin
        got = 1;
        break;
      end
    end
    check("drain_idle", got, 1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_one(input logic [DW-1:0] d, input logic [OW-1:0] e,
                          input string nm);
    int oc, lat;
    oc = out_cnt;
    in_valid = 1'b1;
    in_data = d;
    cyc();
    in_valid = 1'b0;
    check({nm, "_acc"}, acc_f, 1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (out_cnt != oc) begin
        lat = i;
        break;
      end
    end
    check({nm, "_lat"}, lat, 2);
    check(nm, longint'(last_out), longint'(e));
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[k*DIN_W +: DIN_W] = DIN_W'($urandom);
    return r;
  endfunction

  initial begin
    logic [DIN_W-1:0] xv;
    logic [DOUT_W-1:0] ev;
    logic [DW-1:0] vecs [4];
    logic [OW-1:0] hold;
    int sent, oc0, ac0;
    bit got;

    tv[0] = '{4, 3, 0, 128};
    tv[1] = '{4, 2, 0, 255};
    tv[2] = '{4, 3, -20, (RND != 0) ? 37 : 36};
    tv[3] = '{4, 3, -256, 0};
    tv[4] = '{15, 15, -256, (RND != 0) ? 64 : 63};
    tv[5] = '{15, 15, 255, 64};
    tv[6] = '{0, 0, -2, 1};
    tv[7] = '{0, 0, -1, 9};

    model_defaults();
    repeat (2) @(posedge core_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", longint'(out_data), 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      prep_run(tv[i].iss, tv[i].oss);
      xv = DIN_W'(tv[i].x);
      ev = DOUT_W'(tv[i].exp);
      send_one({LANES{xv}}, {LANES{ev}}, $sformatf("tv%0d", i));
      stop_drain();
    end

    prep_run(4, 3);
    for (int i = 0; i < 4; i++) vecs[i] = rand_vec();
    oc0 = out_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      in_data = vecs[sent];
      cyc();
      if (acc_f) sent++;
      if (c == 2) begin
        check("bp_accepted", sent, 2);
        check("bp_in_ready", rdy_s, 0);
        check("bp_out_valid", ov_s, 1);
        hold = od_s;
      end
      if (c == 3) begin
        check("bp_still_2", sent, 2);
        check("bp_stable", longint'(od_s), longint'(hold));
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      in_data = vecs[sent];
      cyc();
      if (acc_f) sent++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", sent, 4);
    stop_drain();
    check("bp_out_count", out_cnt - oc0, 4);

    prep_run(4, 3);
    cfg_w(1, 7, 0, 0);
    xv = '0;
    send_one({LANES{xv}}, {LANES{8'd128}}, "cfg_in_run");
    oc0 = out_cnt;
    ac0 = acc_cnt;
    in_valid = 1'b1;
    in_data = rand_vec();
    cyc();
    in_data = rand_vec();
    cyc();
    in_valid = 1'b0;
    check("flight_accepts", acc_cnt - ac0, 2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    in_valid = 1'b1;
    in_data = rand_vec();
    cyc();
    check("drain_in_ready", rdy_s, 0);
    in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!busy_s) begin
        got = 1;
        break;
      end
    end
    check("flight_idle", got, 1);
    check("flight_out_count", out_cnt - oc0, 2);
    check("flight_accept_total", acc_cnt - ac0, 2);

    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 8; w++)
        cfg_w($urandom_range(0, 3), $urandom_range(0, 7),
              int'($urandom_range(0, 255)) - 128, 1);
      prep_run($urandom_range(0, 8), $urandom_range(0, 10));
      for (int c = 0; c < 150; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = rand_vec();
        out_ready = ($urandom_range(0, 2) != 0);
        cfg_we = ($urandom_range(0, 15) == 0);
        cfg_sel = 2'($urandom);
        cfg_addr = 3'($urandom);
        cfg_wdata = 8'($urandom);
        cyc();
      end
      cfg_we = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      stop_drain();
    end

    model_defaults();
    cfg_w(2, 7, 10, 1);
    cfg_w(1, 7, 55, 1);
    cfg_w(3, 7, 99, 1);
    for (int i = 0; i < NSEG-1; i++) cfg_w(0, i, DBP[i], 1);
    for (int i = 0; i < NSEG-1; i++) begin
      cfg_w(1, i, DCF[i], 1);
      cfg_w(2, i, DBS[i], 1);
    end
    prep_run(4, 3);
    xv = '0;
    send_one({LANES{xv}}, {LANES{8'd20}}, "bias_write");
    stop_drain();

    input_scale_shift = 4'd4;
    prep = 1'b1;
    cyc();
    prep = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    model_defaults();
    exp_q.delete();
    @(negedge core_clk);
    check("rstp_busy", busy, 0);
    check("rstp_out_valid", out_valid, 0);
    check("rstp_in_ready", in_ready, 0);
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();
    check("rstp_stays_idle", busy_s, 0);
    prep_run(4, 3);
    send_one({LANES{xv}}, {LANES{8'd128}}, "rstp_defaults");
    stop_drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
